// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues register-file operands to a registered ALU and writes the result back three cycles later.
module alu_issue_ctrl #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         instr_valid,
   output logic         instr_ready,
   input  logic [2:0]   instr_op,
   input  logic [2:0]   instr_rd,
   input  logic [2:0]   instr_rs,
   input  logic [2:0]   instr_rt,
   input  logic         instr_cin,
   input  logic         ld_en,
   input  logic [2:0]   ld_addr,
   input  logic [n-1:0] ld_data,
   output logic [n-1:0] alu_R2,
   output logic [n-1:0] alu_R3,
   output logic [2:0]   alu_AOp,
   output logic         alu_cin,
   input  logic [n-1:0] alu_R1,
   input  logic         alu_cout,
   output logic         wb_valid,
   output logic [2:0]   wb_rd,
   output logic [n-1:0] wb_data,
   output logic         carry_flag,
   output logic         illegal_op,
   input  logic [2:0]   dbg_addr,
   output logic [n-1:0] dbg_data
);
   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
   state_t       r_state;
   logic [n-1:0] r_regs [8];
   logic [2:0]   r_rd;
   logic [2:0]   r_op;
   logic         w_hs;
   assign instr_ready = (r_state == IDLE) && !rst;
   assign w_hs        = instr_valid && instr_ready;
   assign dbg_data    = r_regs[dbg_addr];
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         for (int i = 0; i < 8; i++) r_regs[i] <= '0;
         r_rd       <= '0;
         r_op       <= '0;
         alu_R2     <= '0;
         alu_R3     <= '0;
         alu_AOp    <= '0;
         alu_cin    <= 1'b0;
         wb_valid   <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
         carry_flag <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               // a load shares the edge with a handshake only if nothing was accepted
               if (w_hs && instr_op == 3'b111) illegal_op <= 1'b1;
               else if (w_hs) begin
                  alu_R2  <= r_regs[instr_rs];
                  alu_R3  <= r_regs[instr_rt];
                  alu_AOp <= instr_op;
                  alu_cin <= instr_cin;
                  r_rd    <= instr_rd;
                  r_op    <= instr_op;
                  r_state <= EXEC;
               end else if (ld_en) r_regs[ld_addr] <= ld_data;
            end
            EXEC: r_state <= WB;
            WB: begin
               r_regs[r_rd] <= alu_R1;
               wb_valid     <= 1'b1;
               wb_rd        <= r_rd;
               wb_data      <= alu_R1;
               if (r_op == 3'b010 || r_op == 3'b011) carry_flag <= alu_cout;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
